// File: rtl/brightness_pixel_writer.sv
// Buffers filtered pixels from the brightness filter in a small FIFO and writes them
// sequentially to the frame SRAM, one acknowledged word at a time.
module brightness_pixel_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_pixels,
  input  logic [31:0]       pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StWrite, StDone} state_e;

  state_e            r_state;
  logic [31:0]       r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;
  logic [15:0]       r_accepted;
  logic [15:0]       r_written;
  logic [15:0]       r_job_len;
  logic [ADDR_W-1:0] r_addr;

  logic            w_push;
  logic            w_pop;
  logic [CntW-1:0] w_count_next;

  // Ready depends on registered state only; a same-cycle pop never frees a full FIFO slot.
  assign pix_ready = ((r_state == StWait) || (r_state == StWrite)) &&
                     (r_count < CntW'(FIFO_DEPTH)) && (r_accepted < r_job_len);

  assign w_push       = pix_valid & pix_ready;
  assign w_pop        = (r_state == StWrite) & mem_ack;
  assign w_count_next = r_count + CntW'(w_push) - CntW'(w_pop);

  assign mem_wen   = (r_state == StWrite);
  assign mem_addr  = mem_wen ? r_addr : '0;
  assign mem_wdata = mem_wen ? r_fifo[r_rptr] : '0;
  assign busy      = (r_state != StIdle);
  assign done      = (r_state == StDone);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= StIdle;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_accepted <= '0;
      r_written  <= '0;
      r_job_len  <= '0;
      r_addr     <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_wptr     <= r_wptr + PtrW'(1);
        r_accepted <= r_accepted + 16'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end

      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_addr     <= base_addr;
            r_job_len  <= num_pixels;
            r_accepted <= '0;
            r_written  <= '0;
            r_state    <= (num_pixels == 16'd0) ? StDone : StWait;
          end
        end
        StWait: begin
          if (r_count != '0) begin
            r_state <= StWrite;
          end
        end
        StWrite: begin
          if (mem_ack) begin
            r_addr    <= r_addr + ADDR_W'(4);
            r_written <= r_written + 16'd1;
            if ((r_written + 16'd1) == r_job_len) begin
              r_state <= StDone;
            end else if (w_count_next != '0) begin
              r_state <= StWrite;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brightness_pixel_writer.sv
// Self-checking bench: directed jobs plus randomized jobs, all outputs compared each cycle
// against a transaction-level model (accepted/written counts and a pixel queue).
module tb_brightness_pixel_writer;

  localparam int DEPTH = 8;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   num_pixels;
  logic [31:0]   pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  brightness_pixel_writer #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .base_addr (base_addr),
    .num_pixels(num_pixels),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: job parameters, counts of pixels accepted/written, pixels in flight.
  bit            m_busy = 1'b0;
  logic [AW-1:0] m_base = '0;
  int            m_len = 0, m_acc = 0, m_wr = 0, m_occ_prev = 0;
  logic [31:0]   m_q[$];

  logic [31:0] src[$];
  int          src_idx   = 0;
  int          valid_pct = 100;
  int          ack_pct   = 100;
  int          done_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    pix_valid = (src_idx < src.size()) && (int'($urandom_range(99)) < valid_pct);
    pix_in    = pix_valid ? src[src_idx] : $urandom();
    mem_ack   = (int'($urandom_range(99)) < ack_pct);
  endtask

  task automatic tick();
    int            occ;
    bit            exp_ready, exp_done, exp_wen;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    occ       = m_acc - m_wr;
    exp_ready = m_busy && (m_acc < m_len) && (occ < DEPTH);
    exp_done  = m_busy && (m_wr == m_len);
    // A pixel becomes visible on the write port one cycle after it lands in an empty FIFO.
    exp_wen   = m_busy && (m_wr < m_len) && (occ > 0) && (m_occ_prev > 0);
    chk("pix_ready", 64'(pix_ready), 64'(exp_ready));
    chk("done", 64'(done), 64'(exp_done));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("mem_wen", 64'(mem_wen), 64'(exp_wen));
    if (exp_wen && m_q.size() > 0) begin
      exp_addr = m_base + AW'(4 * m_wr);
      chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_q[0]));
    end else if (!exp_wen) begin
      chk("mem_wdata_idle", 64'(mem_wdata), 64'd0);
    end
    if (done) done_seen++;
    m_occ_prev = occ;
    if (!n_rst) begin
      m_busy = 1'b0; m_len = 0; m_acc = 0; m_wr = 0; m_occ_prev = 0; m_base = '0;
      m_q.delete();
    end else begin
      if (pix_valid && pix_ready) begin
        m_q.push_back(pix_in);
        m_acc++;
        src_idx++;
      end
      if (mem_wen && mem_ack) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_wr++;
      end
      if (exp_done) begin
        m_busy = 1'b0;
      end else if (!m_busy && start) begin
        m_busy = 1'b1; m_base = base_addr; m_len = int'(num_pixels);
        m_acc = 0; m_wr = 0; m_occ_prev = 0;
        m_q.delete();
      end
    end
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic new_src(input int n);
    src.delete();
    src_idx = 0;
    for (int i = 0; i < n; i++) src.push_back({8'hFF, 24'($urandom())});
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [15:0] len);
    start      = 1'b1;
    base_addr  = base;
    num_pixels = len;
    done_seen  = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_job(input int max_cycles, input int exp_len);
    for (int i = 0; i < max_cycles && m_busy; i++) tick();
    chk("job_timeout", 64'(m_busy), 64'd0);
    tick();
    tick();
    chk("done_pulses", 64'(done_seen), 64'd1);
    chk("writes", 64'(m_wr), 64'(exp_len));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(pix_ready), 64'd0);
    chk({tag, "_wen"}, 64'(mem_wen), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; base_addr = '0; num_pixels = '0;
    pix_in = '0; pix_valid = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    chk_all_zero("reset");

    // Basic job with fixed pixels, ack tied high.
    src.delete(); src_idx = 0;
    src.push_back(32'hFF102030); src.push_back(32'hFF405060);
    src.push_back(32'hFF708090); src.push_back(32'hFFA0B0C0);
    valid_pct = 100; ack_pct = 100;
    start_job(16'h0100, 16'd4);
    finish_job(50, 4);

    // Backpressure: SRAM stalls for 20 cycles, FIFO must fill to exactly its depth.
    new_src(12);
    ack_pct = 0;
    start_job(16'h1000, 16'd12);
    repeat (20) tick();
    chk("bp_accepts", 64'(src_idx), 64'(DEPTH));
    ack_pct = 100;
    finish_job(100, 12);

    // Zero-length job.
    new_src(4);
    start_job(16'h0400, 16'd0);
    finish_job(10, 0);
    chk("zero_accepts", 64'(src_idx), 64'd0);

    // Overrun: more pixels offered than the job length.
    new_src(5);
    start_job(16'h0500, 16'd3);
    finish_job(50, 3);
    repeat (3) tick();
    chk("overrun_accepts", 64'(src_idx), 64'd3);

    // Reset mid-job after two writes.
    new_src(6);
    valid_pct = 100; ack_pct = 50;
    start_job(16'h0600, 16'd6);
    for (int i = 0; i < 200 && m_wr < 2; i++) tick();
    chk("pre_reset_writes", 64'(m_wr), 64'd2);
    n_rst = 1'b0; mem_ack = 1'b0;
    tick();
    n_rst = 1'b1;
    chk_all_zero("midreset");
    tick();
    new_src(2);
    ack_pct = 100;
    start_job(16'h0200, 16'd2);
    finish_job(50, 2);

    // Second start during a job is ignored.
    new_src(5);
    ack_pct = 60;
    start_job(16'h0300, 16'd5);
    repeat (3) tick();
    start = 1'b1; base_addr = 16'h0700; num_pixels = 16'd9;
    tick();
    start = 1'b0;
    finish_job(200, 5);

    // Address wrap at the top of the address space.
    new_src(4);
    ack_pct = 100;
    start_job(16'hFFF8, 16'd4);
    finish_job(50, 4);

    // Randomized jobs.
    for (int j = 0; j < 15; j++) begin
      int len;
      len       = int'($urandom_range(20));
      valid_pct = int'($urandom_range(100, 20));
      ack_pct   = int'($urandom_range(100, 20));
      new_src(len + int'($urandom_range(3)));
      start_job({16'($urandom()) & 16'hFFFC}, 16'(len));
      finish_job(3000, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
